// File: rtl/fft_pkg.sv
// Shared constants and helpers for the radix-2 FFT stage: twiddle derivation
// from a quarter-wave cosine table (N up to 64) and two's-complement saturation.
package fft_pkg;

  // Fractional bits of the internal cosine table
  localparam int TW_TAB_BITS = 30;

  function automatic int tw_frac(input int width);
    return width - 2;
  endfunction

  // cos(2*pi*m/64) scaled by 2^30, m = 0..16
  function automatic longint cos64(input int m);
    case (m)
      0:  return 64'sd1073741824;
      1:  return 64'sd1068571464;
      2:  return 64'sd1053110176;
      3:  return 64'sd1027506862;
      4:  return 64'sd992008094;
      5:  return 64'sd946955747;
      6:  return 64'sd892783698;
      7:  return 64'sd830013654;
      8:  return 64'sd759250125;
      9:  return 64'sd681174602;
      10: return 64'sd596538995;
      11: return 64'sd506158392;
      12: return 64'sd410903207;
      13: return 64'sd311690799;
      14: return 64'sd209476638;
      15: return 64'sd105245103;
      default: return 64'sd0;
    endcase
  endfunction

  // Real part of W = exp(-j*2*pi*k/n), k < n/2, rounded to frac bits
  function automatic int tw_cos(input int k, input int n, input int frac);
    int     m;
    longint c;
    m = (k * 64) / n;
    c = (m <= 16) ? cos64(m) : -cos64(32 - m);
    return int'((c + (64'sd1 <<< (TW_TAB_BITS - frac - 1))) >>> (TW_TAB_BITS - frac));
  endfunction

  // sin(2*pi*k/n); the twiddle imaginary part is its negation
  function automatic int tw_sin(input int k, input int n, input int frac);
    int     m;
    longint s;
    m = (k * 64) / n;
    s = (m <= 16) ? cos64(16 - m) : cos64(m - 16);
    return int'((s + (64'sd1 <<< (TW_TAB_BITS - frac - 1))) >>> (TW_TAB_BITS - frac));
  endfunction

  function automatic longint sat_val(input longint x, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic sat_hit(input longint x, input int w);
    return sat_val(x, w) != x;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// One radix-2 DIT butterfly: twiddle multiply on the b input (pre-register half)
// and add/sub, shift, saturate on registered operands. Rounding: FFT_STAGE_ROUND_EN.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TW_RE   = 0,
  parameter int TW_IM   = 0,
  parameter int TW_FRAC = 14,
  parameter int SH      = 1
) (
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic signed [WIDTH:0]   wb_re,
  output logic signed [WIDTH:0]   wb_im,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH:0]   pwb_re,
  input  logic signed [WIDTH:0]   pwb_im,
  output logic signed [WIDTH-1:0] y0_re,
  output logic signed [WIDTH-1:0] y0_im,
  output logic signed [WIDTH-1:0] y1_re,
  output logic signed [WIDTH-1:0] y1_im,
  output logic                    sat
);

  localparam int PW = 2 * WIDTH + 2;
  localparam int SW = WIDTH + 2;

  localparam logic signed [PW-1:0] WR = PW'(TW_RE);
  localparam logic signed [PW-1:0] WI = PW'(TW_IM);

`ifdef FFT_STAGE_ROUND_EN
  localparam logic signed [PW-1:0] P_RND = (PW'(1) <<< TW_FRAC) >>> 1;
  localparam logic signed [SW-1:0] S_RND = (SW'(1) <<< SH) >>> 1;
`else
  localparam logic signed [PW-1:0] P_RND = '0;
  localparam logic signed [SW-1:0] S_RND = '0;
`endif

  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] pi;
  logic signed [SW-1:0] s0r;
  logic signed [SW-1:0] s0i;
  logic signed [SW-1:0] s1r;
  logic signed [SW-1:0] s1i;

  always_comb begin
    pr    = WR * PW'(b_re) - WI * PW'(b_im);
    pi    = WR * PW'(b_im) + WI * PW'(b_re);
    wb_re = (WIDTH+1)'((pr + P_RND) >>> TW_FRAC);
    wb_im = (WIDTH+1)'((pi + P_RND) >>> TW_FRAC);
  end

  // |W*b| < 2^WIDTH, so WIDTH+2 bits hold a +/- W*b without wrap
  always_comb begin
    s0r   = (SW'(a_re) + SW'(pwb_re) + S_RND) >>> SH;
    s0i   = (SW'(a_im) + SW'(pwb_im) + S_RND) >>> SH;
    s1r   = (SW'(a_re) - SW'(pwb_re) + S_RND) >>> SH;
    s1i   = (SW'(a_im) - SW'(pwb_im) + S_RND) >>> SH;
    y0_re = WIDTH'(sat_val(longint'(s0r), WIDTH));
    y0_im = WIDTH'(sat_val(longint'(s0i), WIDTH));
    y1_re = WIDTH'(sat_val(longint'(s1r), WIDTH));
    y1_im = WIDTH'(sat_val(longint'(s1i), WIDTH));
    sat   = sat_hit(longint'(s0r), WIDTH) | sat_hit(longint'(s0i), WIDTH) |
            sat_hit(longint'(s1r), WIDTH) | sat_hit(longint'(s1i), WIDTH);
  end

endmodule

// File: rtl/fft_r2_stage.sv
// One radix-2 DIT FFT stage over a full N-point frame, two-register pipeline.
// Optional round-half-up on all shifts via FFT_STAGE_ROUND_EN.
module fft_r2_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int STAGE = 0,
  parameter int Q_IN  = 12,
  parameter int Q_OUT = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_re,
  input  logic [N*WIDTH-1:0]   in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WIDTH-1:0]   out_re,
  output logic [N*WIDTH-1:0]   out_im,
  output logic                 ovf
);

  localparam int SPAN  = 1 << STAGE;
  localparam int NP    = N / 2;
  localparam int KSTEP = N / (2 * SPAN);
  localparam int TWF   = tw_frac(WIDTH);
  localparam int SH    = Q_IN - Q_OUT;

  // Lower index of butterfly pair p: insert a 0 at bit STAGE of p
  function automatic int lo_idx(input int p);
    return ((p >> STAGE) << (STAGE + 1)) | (p & (SPAN - 1));
  endfunction

  logic v1;
  logic v2;
  logic p1_load;
  logic p2_load;

  logic signed [WIDTH-1:0] a_re_q  [NP];
  logic signed [WIDTH-1:0] a_im_q  [NP];
  logic signed [WIDTH:0]   wb_re_q [NP];
  logic signed [WIDTH:0]   wb_im_q [NP];
  logic signed [WIDTH:0]   wb_re_c [NP];
  logic signed [WIDTH:0]   wb_im_c [NP];
  logic signed [WIDTH-1:0] y0_re   [NP];
  logic signed [WIDTH-1:0] y0_im   [NP];
  logic signed [WIDTH-1:0] y1_re   [NP];
  logic signed [WIDTH-1:0] y1_im   [NP];
  logic [NP-1:0]           sat_vec;

  // valid/ready: a frame moves across a boundary on a clock edge where the
  // sender's valid and the receiver's ready are both high; a sender holds
  // valid and data until that edge. Ready here looks through a draining P2.
  assign p2_load   = !v2 || out_ready;
  assign p1_load   = !v1 || p2_load;
  assign in_ready  = p1_load;
  assign out_valid = v2;

  for (genvar p = 0; p < NP; p++) begin : g_bfly
    localparam int LO = lo_idx(p);
    localparam int HI = LO + SPAN;
    localparam int K  = (p & (SPAN - 1)) * KSTEP;

    fft_bfly #(
      .WIDTH   (WIDTH),
      .TW_RE   (tw_cos(K, N, TWF)),
      .TW_IM   (-tw_sin(K, N, TWF)),
      .TW_FRAC (TWF),
      .SH      (SH)
    ) u_bfly (
      .b_re   (in_re[HI*WIDTH +: WIDTH]),
      .b_im   (in_im[HI*WIDTH +: WIDTH]),
      .wb_re  (wb_re_c[p]),
      .wb_im  (wb_im_c[p]),
      .a_re   (a_re_q[p]),
      .a_im   (a_im_q[p]),
      .pwb_re (wb_re_q[p]),
      .pwb_im (wb_im_q[p]),
      .y0_re  (y0_re[p]),
      .y0_im  (y0_im[p]),
      .y1_re  (y1_re[p]),
      .y1_im  (y1_im[p]),
      .sat    (sat_vec[p])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      ovf    <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      for (int p = 0; p < NP; p++) begin
        a_re_q[p]  <= '0;
        a_im_q[p]  <= '0;
        wb_re_q[p] <= '0;
        wb_im_q[p] <= '0;
      end
    end else begin
      if (p1_load) begin
        v1 <= in_valid;
        if (in_valid) begin
          for (int p = 0; p < NP; p++) begin
            a_re_q[p]  <= in_re[lo_idx(p)*WIDTH +: WIDTH];
            a_im_q[p]  <= in_im[lo_idx(p)*WIDTH +: WIDTH];
            wb_re_q[p] <= wb_re_c[p];
            wb_im_q[p] <= wb_im_c[p];
          end
        end
      end
      if (p2_load) begin
        v2 <= v1;
        if (v1) begin
          for (int p = 0; p < NP; p++) begin
            out_re[lo_idx(p)*WIDTH +: WIDTH]          <= y0_re[p];
            out_im[lo_idx(p)*WIDTH +: WIDTH]          <= y0_im[p];
            out_re[(lo_idx(p)+SPAN)*WIDTH +: WIDTH]   <= y1_re[p];
            out_im[(lo_idx(p)+SPAN)*WIDTH +: WIDTH]   <= y1_im[p];
          end
          ovf <= ovf | (|sat_vec);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_r2_stage.sv
// Directed bench for fft_r2_stage: three instances (STAGE=1, STAGE=0, STAGE=0 unscaled)
// share one stimulus bus; each feature task checks its own hand-computed results.
module tb_fft_r2_stage;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int NW = N * W;

`ifdef FFT_STAGE_ROUND_EN
  localparam logic [W-1:0] RND_EXP = 16'h0001;
`else
  localparam logic [W-1:0] RND_EXP = 16'h0000;
`endif

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic [NW-1:0] in_re;
  logic [NW-1:0] in_im;

  logic in_ready_1, out_valid_1, ovf_1;
  logic in_ready_0, out_valid_0, ovf_0;
  logic in_ready_q, out_valid_q, ovf_q;
  logic [NW-1:0] out_re_1, out_im_1;
  logic [NW-1:0] out_re_0, out_im_0;
  logic [NW-1:0] out_re_q, out_im_q;

  logic [NW-1:0] z;
  logic [NW-1:0] exp_q[$];

  int errors;
  int checks;

  fft_r2_stage #(.WIDTH(W), .N(N), .STAGE(1), .Q_IN(12), .Q_OUT(11)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_1), .out_ready(out_ready),
    .out_re(out_re_1), .out_im(out_im_1), .ovf(ovf_1)
  );

  fft_r2_stage #(.WIDTH(W), .N(N), .STAGE(0), .Q_IN(12), .Q_OUT(11)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_0),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_0), .out_ready(out_ready),
    .out_re(out_re_0), .out_im(out_im_0), .ovf(ovf_0)
  );

  fft_r2_stage #(.WIDTH(W), .N(N), .STAGE(0), .Q_IN(12), .Q_OUT(12)) u_s0q (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_q),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid_q), .out_ready(out_ready),
    .out_re(out_re_q), .out_im(out_im_q), .ovf(ovf_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NW-1:0] put(input logic [NW-1:0] v, input int idx,
                                        input logic [W-1:0] val);
    logic [NW-1:0] r;
    r = v;
    r[idx*W +: W] = val;
    return r;
  endfunction

  function automatic logic [NW-1:0] frame_in(input int n);
    logic [NW-1:0] r;
    r = '0;
    r[0 +: W] = W'(16'h0100 * (n + 1));
    return r;
  endfunction

  // STAGE=1 result of frame_in(n): x0 pairs with x2 under W=1, so y0 = y2 = x0/2
  function automatic logic [NW-1:0] frame_exp(input int n);
    logic [NW-1:0] r;
    r = '0;
    r[0 +: W]   = W'(16'h0080 * (n + 1));
    r[2*W +: W] = W'(16'h0080 * (n + 1));
    return r;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NW-1:0] re, input logic [NW-1:0] im);
    in_re    = re;
    in_im    = im;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({out_valid_1, out_valid_0, out_valid_q} !== 3'b000) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 000", {out_valid_1, out_valid_0, out_valid_q});
    end
    checks++;
    if ({ovf_1, ovf_0, ovf_q} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 000", {ovf_1, ovf_0, ovf_q});
    end
    checks++;
    if ((out_re_1 | out_im_1 | out_re_0 | out_im_0 | out_re_q | out_im_q) !== z) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", out_re_1 | out_im_1 | out_re_0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready_1, in_ready_0, in_ready_q} !== 3'b111) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 111", {in_ready_1, in_ready_0, in_ready_q});
    end
  endtask

  task automatic test_impulse();
    send(put(z, 0, 16'h1000), z);
    checks++;
    if (out_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL impulse_early_valid: got %b want 0", out_valid_1);
    end
    tick();
    checks++;
    if (out_valid_1 !== 1'b1) begin
      errors++;
      $display("FAIL impulse_latency: got %b want 1", out_valid_1);
    end
    checks++;
    if (out_re_1 !== put(put(z, 0, 16'h0800), 2, 16'h0800) || out_im_1 !== z) begin
      errors++;
      $display("FAIL impulse_s1: got re %h im %h want re %h im 0", out_re_1, out_im_1,
               put(put(z, 0, 16'h0800), 2, 16'h0800));
    end
    checks++;
    if (ovf_1 !== 1'b0) begin
      errors++;
      $display("FAIL impulse_ovf: got %b want 0", ovf_1);
    end
    checks++;
    if (out_re_0 !== put(put(z, 0, 16'h0800), 1, 16'h0800)) begin
      errors++;
      $display("FAIL impulse_s0: got %h want %h", out_re_0, put(put(z, 0, 16'h0800), 1, 16'h0800));
    end
    checks++;
    if (out_re_q !== put(put(z, 0, 16'h1000), 1, 16'h1000)) begin
      errors++;
      $display("FAIL impulse_s0q: got %h want %h", out_re_q, put(put(z, 0, 16'h1000), 1, 16'h1000));
    end
    tick();
    checks++;
    if (out_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL impulse_drain: got %b want 0", out_valid_1);
    end
  endtask

  task automatic test_twiddle();
    send(put(put(z, 1, 16'h1000), 3, 16'h1000), z);
    tick();
    checks++;
    if (out_re_1 !== put(put(z, 1, 16'h0800), 3, 16'h0800)) begin
      errors++;
      $display("FAIL twiddle_s1_re: got %h want %h", out_re_1, put(put(z, 1, 16'h0800), 3, 16'h0800));
    end
    checks++;
    if (out_im_1 !== put(put(z, 1, 16'hF800), 3, 16'h0800)) begin
      errors++;
      $display("FAIL twiddle_s1_im: got %h want %h", out_im_1, put(put(z, 1, 16'hF800), 3, 16'h0800));
    end
    checks++;
    if (out_re_0 !== put(put(put(put(z, 0, 16'h0800), 1, 16'hF800), 2, 16'h0800), 3, 16'hF800)
        || out_im_0 !== z) begin
      errors++;
      $display("FAIL twiddle_s0: got re %h im %h", out_re_0, out_im_0);
    end
    tick();
  endtask

  task automatic test_saturate();
    send(put(put(z, 0, 16'h7000), 1, 16'h7000), z);
    tick();
    checks++;
    if (out_re_q !== put(z, 0, 16'h7FFF)) begin
      errors++;
      $display("FAIL sat_value: got %h want %h", out_re_q, put(z, 0, 16'h7FFF));
    end
    checks++;
    if (ovf_q !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf_set: got %b want 1", ovf_q);
    end
    checks++;
    if (out_re_0 !== put(z, 0, 16'h7000) || {ovf_0, ovf_1} !== 2'b00) begin
      errors++;
      $display("FAIL sat_scaled_no_ovf: got %h ovf %b%b want %h ovf 00", out_re_0, ovf_0, ovf_1,
               put(z, 0, 16'h7000));
    end
    send(z, z);
    tick();
    checks++;
    if (ovf_q !== 1'b1 || out_re_q !== z) begin
      errors++;
      $display("FAIL sat_ovf_sticky: got ovf %b re %h want ovf 1 re 0", ovf_q, out_re_q);
    end
  endtask

  task automatic test_round();
    send(put(z, 0, 16'h0001), z);
    tick();
    checks++;
    if (out_re_0 !== put(put(z, 0, RND_EXP), 1, RND_EXP)) begin
      errors++;
      $display("FAIL round_s0: got %h want %h", out_re_0, put(put(z, 0, RND_EXP), 1, RND_EXP));
    end
    checks++;
    if (out_re_1 !== put(put(z, 0, RND_EXP), 2, RND_EXP)) begin
      errors++;
      $display("FAIL round_s1: got %h want %h", out_re_1, put(put(z, 0, RND_EXP), 2, RND_EXP));
    end
    checks++;
    if (out_re_q !== put(put(z, 0, 16'h0001), 1, 16'h0001)) begin
      errors++;
      $display("FAIL round_unscaled: got %h want %h", out_re_q, put(put(z, 0, 16'h0001), 1, 16'h0001));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int            sent;
    int            got;
    logic          held_v;
    logic [NW-1:0] held;
    logic [NW-1:0] exp_v;
    exp_q.delete();
    sent   = 0;
    got    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      out_ready = (c >= 4);
      if (sent < 3) begin
        in_valid = 1'b1;
        in_re    = frame_in(sent);
      end else begin
        in_valid = 1'b0;
        in_re    = '0;
      end
      in_im = '0;
      #1;
      if (c == 2 || c == 3) begin
        checks++;
        if (in_ready_1 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_in_ready_stall: cycle %0d got %b want 0", c, in_ready_1);
        end
      end
      if (c == 3) begin
        checks++;
        if (sent != 2) begin
          errors++;
          $display("FAIL b2b_accepted: got %0d want 2", sent);
        end
      end
      if (held_v) begin
        checks++;
        if (out_valid_1 !== 1'b1 || out_re_1 !== held) begin
          errors++;
          $display("FAIL b2b_hold: cycle %0d got valid %b re %h want valid 1 re %h",
                   c, out_valid_1, out_re_1, held);
        end
      end
      held_v = out_valid_1 && !out_ready;
      held   = out_re_1;
      if (out_valid_1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_frame: got %h want none", out_re_1);
        end else begin
          exp_v = exp_q.pop_front();
          if (out_re_1 !== exp_v) begin
            errors++;
            $display("FAIL b2b_order: frame %0d got %h want %h", got, out_re_1, exp_v);
          end
        end
        got++;
      end
      if (in_valid && in_ready_1) begin
        exp_q.push_back(frame_exp(sent));
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    in_re     = '0;
    out_ready = 1'b1;
    checks++;
    if (got != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: got %0d frames, %0d pending, want 3 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_re     = frame_in(0);
    tick();
    in_re     = frame_in(1);
    tick();
    in_valid  = 1'b0;
    in_re     = '0;
    #1;
    checks++;
    if ({out_valid_1, in_ready_1, ovf_q} !== 3'b101) begin
      errors++;
      $display("FAIL midrst_pre: got valid/ready/ovf %b want 101", {out_valid_1, in_ready_1, ovf_q});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_1, out_valid_0, out_valid_q, ovf_q} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_clear: got %b want 0000", {out_valid_1, out_valid_0, out_valid_q, ovf_q});
    end
    checks++;
    if (out_re_1 !== z) begin
      errors++;
      $display("FAIL midrst_data: got %h want 0", out_re_1);
    end
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    send(frame_in(2), z);
    checks++;
    if (out_valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: got %b want 0", out_valid_1);
    end
    tick();
    checks++;
    if (out_valid_1 !== 1'b1 || out_re_1 !== frame_exp(2)) begin
      errors++;
      $display("FAIL midrst_latency: got valid %b re %h want valid 1 re %h",
               out_valid_1, out_re_1, frame_exp(2));
    end
    tick();
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    z         = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_re     = '0;
    in_im     = '0;
    test_reset();
    test_impulse();
    test_twiddle();
    test_saturate();
    test_round();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
